gate_net_arb: RTL and testbench

GATE_NET_ARB -- requirements
Module: gate_net_arb

---
 rtl/gate_net_pkg.sv | 26 ++
 rtl/gate_net_core.sv | 25 ++
 rtl/gate_net_arb.sv | 143 ++++++++++++++
 tb/tb_gate_net_arb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_net_pkg.sv
// rtl/gate_net_pkg.sv - shared types and bit positions for the gate network arbiter
package gate_net_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Operand bit positions inside the 4-bit input word {a,b,c,d}
    localparam int BIT_A = 3;
    localparam int BIT_B = 2;
    localparam int BIT_C = 1;
    localparam int BIT_D = 0;

    // Result bit positions inside the 3-bit output word {e,f,g}
    localparam int BIT_E = 2;
    localparam int BIT_F = 1;
    localparam int BIT_G = 0;

    localparam int OPND_W = 4;
    localparam int RES_W  = 3;
    localparam int WAIT_W = 8;

endpackage

// File: rtl/gate_net_core.sv
// rtl/gate_net_core.sv - combinational shared gate network
module gate_net_core
    import gate_net_pkg::*;
(
    input  logic [OPND_W-1:0] opnd,
    output logic [RES_W-1:0]  res
);

    logic e;
    logic f;
    logic g;

    assign e = ~(opnd[BIT_A] & opnd[BIT_B]);
    assign f = ~(e & opnd[BIT_C]);
    assign g = ~f & opnd[BIT_D];

    // Pack the three gate outputs into the result word
    always_comb begin
        res        = '0;
        res[BIT_E] = e;
        res[BIT_F] = f;
        res[BIT_G] = g;
    end

endmodule

// File: rtl/gate_net_arb.sv
// rtl/gate_net_arb.sv - round-robin arbiter sharing one gate network between two requesters
module gate_net_arb
    import gate_net_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [OPND_W-1:0] in0,
    input  logic [OPND_W-1:0] in1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_id,
    output logic [RES_W-1:0]  out_efg,
    output logic              drop
);

    localparam logic [WAIT_W-1:0] TIMEOUT_V  = WAIT_W'(TIMEOUT);
    localparam logic              TIMEOUT_EN = (TIMEOUT != 0);

    state_t              state_q, state_d;
    logic [OPND_W-1:0]   opnd_q, opnd_d;
    logic                win_q, win_d;
    logic                last_q, last_d;
    logic                gnt0_q, gnt0_d;
    logic                gnt1_q, gnt1_d;
    logic                busy_q, busy_d;
    logic                out_valid_q, out_valid_d;
    logic                out_id_q, out_id_d;
    logic [RES_W-1:0]    out_efg_q, out_efg_d;
    logic                drop_q, drop_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                win_sel;
    logic [RES_W-1:0]    core_res;

    gate_net_core u_core (
        .opnd (opnd_q),
        .res  (core_res)
    );

    // Next-state and registered-output logic for the IDLE/EVAL/RESP sequence
    always_comb begin
        state_d     = state_q;
        opnd_d      = opnd_q;
        win_d       = win_q;
        last_d      = last_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_efg_d   = out_efg_q;
        drop_d      = 1'b0;
        wait_d      = wait_q;
        // On a tie the requester not served last wins; otherwise the lone requester
        win_sel     = (req0 && req1) ? ~last_q : req1;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    opnd_d  = win_sel ? in1 : in0;
                    win_d   = win_sel;
                    gnt0_d  = ~win_sel;
                    gnt1_d  = win_sel;
                    busy_d  = 1'b1;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                out_efg_d   = core_res;
                out_id_d    = win_q;
                out_valid_d = 1'b1;
                wait_d      = '0;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    last_d      = out_id_q;
                    state_d     = ST_IDLE;
                end else if (TIMEOUT_EN && (wait_q == TIMEOUT_V)) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    drop_d      = 1'b1;
                    last_d      = out_id_q;
                    state_d     = ST_IDLE;
                end else if (wait_q != {WAIT_W{1'b1}}) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; last-served starts at 1 so req0 wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            opnd_q      <= '0;
            win_q       <= 1'b0;
            last_q      <= 1'b1;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_id_q    <= 1'b0;
            out_efg_q   <= '0;
            drop_q      <= 1'b0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            opnd_q      <= opnd_d;
            win_q       <= win_d;
            last_q      <= last_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_efg_q   <= out_efg_d;
            drop_q      <= drop_d;
            wait_q      <= wait_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_efg   = out_efg_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_gate_net_arb.sv
// tb/tb_gate_net_arb.sv - scoreboard bench for gate_net_arb
module tb_gate_net_arb;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [3:0] in0 = 4'h0;
    logic [3:0] in1 = 4'h0;
    logic       out_ready = 1'b0;

    logic       gnt0, gnt1, busy, out_valid, out_id, drop;
    logic [2:0] out_efg;
    logic       to_gnt0, to_gnt1, to_busy, to_valid, to_id, to_drop;
    logic [2:0] to_efg;

    int checks = 0;
    int failures = 0;
    int n_xfer = 0;
    bit m_last = 1'b1;
    logic [3:0] sb_q[$];
    int id_log[$];

    always #5 clk = ~clk;

    gate_net_arb dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .in0(in0), .in1(in1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_id(out_id), .out_efg(out_efg), .drop(drop)
    );

    gate_net_arb #(.TIMEOUT(3)) dut_to (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .in0(in0), .in1(in1),
        .gnt0(to_gnt0), .gnt1(to_gnt1), .busy(to_busy), .out_valid(to_valid),
        .out_ready(out_ready), .out_id(to_id), .out_efg(to_efg), .drop(to_drop)
    );

    function automatic logic [2:0] model_efg(input logic [3:0] v);
        logic e, f, g;
        e = !(v[3] && v[2]);
        f = !(e && v[1]);
        g = !f && v[0];
        return {e, f, g};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        sb_q.delete();
        m_last = 1'b1;
    endtask

    // One transaction: drive requests, expect the model's winner, stall, then accept
    task automatic txn(input bit r0, input bit r1, input logic [3:0] v0, input logic [3:0] v1, input int stall);
        bit w;
        bit got;
        logic [2:0] efg0;
        in0 = v0; in1 = v1; req0 = r0; req1 = r1; out_ready = 1'b0;
        w = (r0 && r1) ? ~m_last : r1;
        efg0 = model_efg(w ? v1 : v0);
        sb_q.push_back({w, efg0});
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = gnt0 | gnt1;
        end
        chk("gnt_seen", {7'd0, got}, 8'd1);
        chk("gnt_who", {7'd0, gnt1}, {7'd0, w});
        if (w) req1 = 1'b0; else req0 = 1'b0;
        tick();
        chk("valid_rise", {7'd0, out_valid}, 8'd1);
        chk("gnt_pulse", {6'd0, gnt0, gnt1}, 8'd0);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("valid_hold", {7'd0, out_valid}, 8'd1);
            chk("efg_stable", {5'd0, out_efg}, {5'd0, efg0});
        end
        out_ready = 1'b1;
        tick();
        chk("valid_fall", {7'd0, out_valid}, 8'd0);
        out_ready = 1'b0;
    endtask

    // Scoreboard pop and cycle invariants, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            chk("gnt_excl", {7'd0, gnt0 & gnt1}, 8'd0);
            chk("to_drop_valid_excl", {7'd0, to_drop & to_valid}, 8'd0);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected", 8'd1, 8'd0);
                end else begin
                    logic [3:0] e;
                    e = sb_q.pop_front();
                    chk("sb_id", {7'd0, out_id}, {7'd0, e[3]});
                    chk("sb_efg", {5'd0, out_efg}, {5'd0, e[2:0]});
                    m_last = e[3];
                    id_log.push_back(int'(out_id));
                    n_xfer++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        do_reset();
        // reset values
        chk("rst_gnt", {6'd0, gnt0, gnt1}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_id", {7'd0, out_id}, 8'd0);
        chk("rst_efg", {5'd0, out_efg}, 8'd0);
        chk("rst_drop", {7'd0, drop}, 8'd0);

        // single request, direct checks of the known answer
        txn(1'b1, 1'b0, 4'hF, 4'h0, 0);
        chk("single_efg", {5'd0, out_efg}, 8'b010);
        chk("single_id", {7'd0, out_id}, 8'd0);
        chk("single_busy", {7'd0, busy}, 8'd0);

        // tie after reset: req0 first, then req1
        do_reset();
        base = id_log.size();
        txn(1'b1, 1'b1, 4'b0011, 4'b0010, 0);
        chk("tie_efg0", {5'd0, out_efg}, 8'b101);
        txn(1'b0, 1'b1, 4'b0011, 4'b0010, 0);
        chk("tie_efg1", {5'd0, out_efg}, 8'b100);
        chk("tie_id1", {7'd0, out_id}, 8'd1);
        chk("tie_count", 8'(id_log.size() - base), 8'd2);

        // fairness: both held for six transactions
        do_reset();
        base = id_log.size();
        for (int i = 0; i < 6; i++)
            txn(1'b1, 1'b1, 4'(i * 3), 4'(15 - i), i % 3);
        req0 = 1'b0; req1 = 1'b0;
        chk("fair_count", 8'(id_log.size() - base), 8'd6);
        for (int i = 0; i < 6 && base + i < id_log.size(); i++)
            chk("fair_seq", 8'(id_log[base + i]), 8'(i % 2));

        // backpressure: five stalled cycles, one transfer
        do_reset();
        base = n_xfer;
        txn(1'b0, 1'b1, 4'h0, 4'b1101, 5);
        chk("bp_efg", {5'd0, out_efg}, 8'b010);
        chk("bp_single", 8'(n_xfer - base), 8'd1);

        // timeout on the TIMEOUT=3 instance
        do_reset();
        in0 = 4'hF; req0 = 1'b1; out_ready = 1'b0;
        tick();
        chk("to_gnt", {7'd0, to_gnt0}, 8'd1);
        req0 = 1'b0;
        tick();
        chk("to_valid", {7'd0, to_valid}, 8'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_hold", {7'd0, to_valid}, 8'd1);
            chk("to_nodrop", {7'd0, to_drop}, 8'd0);
        end
        tick();
        chk("to_drop", {7'd0, to_drop}, 8'd1);
        chk("to_valid_fall", {7'd0, to_valid}, 8'd0);
        chk("to_busy", {7'd0, to_busy}, 8'd0);
        tick();
        chk("to_drop_pulse", {7'd0, to_drop}, 8'd0);

        // ready on the timeout edge: transfer wins
        do_reset();
        in0 = 4'hF; req0 = 1'b1;
        sb_q.push_back({1'b0, model_efg(4'hF)});
        tick();
        req0 = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) tick();
        chk("to_race_valid", {7'd0, to_valid}, 8'd1);
        out_ready = 1'b1;
        tick();
        chk("to_race_nodrop", {7'd0, to_drop}, 8'd0);
        chk("to_race_valid_fall", {7'd0, to_valid}, 8'd0);
        chk("to_race_busy", {7'd0, to_busy}, 8'd0);
        out_ready = 1'b0;
        tick();
        chk("to_race_nodrop2", {7'd0, to_drop}, 8'd0);

        // reset while in RESP after req0 was served last
        do_reset();
        txn(1'b1, 1'b0, 4'hF, 4'h0, 0);
        in1 = 4'hD; req1 = 1'b1;
        tick();
        chk("mid_gnt1", {7'd0, gnt1}, 8'd1);
        req1 = 1'b0;
        tick();
        chk("mid_valid", {7'd0, out_valid}, 8'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb_q.delete();
        m_last = 1'b1;
        chk("mid_rst_valid", {7'd0, out_valid}, 8'd0);
        chk("mid_rst_busy", {7'd0, busy}, 8'd0);
        chk("mid_rst_efg", {5'd0, out_efg}, 8'd0);
        chk("mid_rst_id", {7'd0, out_id}, 8'd0);
        tick();
        chk("mid_quiet", {4'd0, gnt0, gnt1, out_valid, drop}, 8'd0);
        base = id_log.size();
        txn(1'b1, 1'b1, 4'b0011, 4'b0010, 0);
        req1 = 1'b0;
        chk("mid_tie_count", 8'(id_log.size() - base), 8'd1);
        if (id_log.size() > base)
            chk("mid_tie_id", 8'(id_log[base]), 8'd0);
        chk("sb_drained", 8'(sb_q.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
